// File: rtl/dmem_responder.sv
// Single-port word memory behind a valid/ready request/response handshake with fixed access latency.
// Optional misaligned-access error reporting is enabled with DMEM_MISALIGN_ERR_EN.
module dmem_responder #(
  parameter int ADDRESS_WIDTH = 8,
  parameter int DATA_WIDTH    = 32,
  parameter int LATENCY       = 2
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      req_valid,
  output logic                      req_ready,
  input  logic                      req_we,
  input  logic [ADDRESS_WIDTH-1:0]  req_addr,
  input  logic [DATA_WIDTH-1:0]     req_wdata,
  input  logic [DATA_WIDTH/8-1:0]   req_be,
  output logic                      rsp_valid,
  input  logic                      rsp_ready,
  output logic [DATA_WIDTH-1:0]     rsp_rdata
`ifdef DMEM_MISALIGN_ERR_EN
  ,
  output logic                      rsp_err
`endif
);

  localparam int NB    = DATA_WIDTH / 8;
  localparam int IW    = ADDRESS_WIDTH - 2;
  localparam int WORDS = 1 << IW;

  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

  state_t                state_q, state_d;
  logic [3:0]            cnt_q, cnt_d;
  logic                  we_q, we_d;
  logic [IW-1:0]         idx_q, idx_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [NB-1:0]         be_q, be_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic                  access;
  logic                  bad;
  logic                  mem_we;

  logic [DATA_WIDTH-1:0] mem_q [WORDS];

`ifdef DMEM_MISALIGN_ERR_EN
  localparam logic [NB-1:0] LO_HALF = NB'((1 << (NB / 2)) - 1);
  localparam logic [NB-1:0] HI_HALF = LO_HALF << (NB / 2);

  logic [1:0] off_q, off_d;
  logic       err_q, err_d;

  // Only naturally aligned byte, halfword and word store masks are legal.
  function automatic logic be_legal(input logic [NB-1:0] be);
    be_legal = (be == '0) || $onehot(be) || (be == LO_HALF) ||
               (be == HI_HALF) || (be == {NB{1'b1}});
  endfunction

  assign bad     = we_q ? !be_legal(be_q) : (off_q != 2'b00);
  assign rsp_err = err_q;
`else
  logic unused_addr_lsb;
  assign unused_addr_lsb = ^req_addr[1:0];
  assign bad             = 1'b0;
`endif

  assign req_ready = (state_q == IDLE);
  assign rsp_valid = (state_q == RESP);
  assign rsp_rdata = rdata_q;
  assign mem_we    = access && rst && we_q && !bad;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    we_d    = we_q;
    idx_d   = idx_q;
    wdata_d = wdata_q;
    be_d    = be_q;
    rdata_d = rdata_q;
    access  = 1'b0;
`ifdef DMEM_MISALIGN_ERR_EN
    off_d   = off_q;
    err_d   = err_q;
`endif
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          state_d = BUSY;
          cnt_d   = 4'(LATENCY - 1);
          we_d    = req_we;
          idx_d   = req_addr[ADDRESS_WIDTH-1:2];
          wdata_d = req_wdata;
          be_d    = req_be;
`ifdef DMEM_MISALIGN_ERR_EN
          off_d   = req_addr[1:0];
`endif
        end
      end
      BUSY: begin
        if (cnt_q != 4'd0) begin
          cnt_d = cnt_q - 4'd1;
        end else begin
          state_d = RESP;
          access  = 1'b1;
          rdata_d = (we_q || bad) ? '0 : mem_q[idx_q];
`ifdef DMEM_MISALIGN_ERR_EN
          err_d   = bad;
`endif
        end
      end
      RESP: begin
        if (rsp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      rdata_q <= '0;
`ifdef DMEM_MISALIGN_ERR_EN
      err_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
`ifdef DMEM_MISALIGN_ERR_EN
      err_q   <= err_d;
`endif
    end
  end

  // Captured request fields are only consumed in BUSY, so they need no reset.
  always_ff @(posedge clk) begin
    we_q    <= we_d;
    idx_q   <= idx_d;
    wdata_q <= wdata_d;
    be_q    <= be_d;
`ifdef DMEM_MISALIGN_ERR_EN
    off_q   <= off_d;
`endif
  end

  always_ff @(posedge clk) begin
    if (mem_we) begin
      for (int i = 0; i < NB; i++) begin
        if (be_q[i]) mem_q[idx_q][i*8 +: 8] <= wdata_q[i*8 +: 8];
      end
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
// Directed, scoreboard-checked bench for dmem_responder; builds with or without DMEM_MISALIGN_ERR_EN.
module tb_dmem_responder;

  localparam int AW  = 8;
  localparam int DW  = 32;
  localparam int NB  = DW / 8;
  localparam int LAT = 2;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          req_valid = 1'b0;
  logic          req_we = 1'b0;
  logic [AW-1:0] req_addr = '0;
  logic [DW-1:0] req_wdata = '0;
  logic [NB-1:0] req_be = '0;
  logic          rsp_ready = 1'b0;
  logic          req_ready;
  logic          rsp_valid;
  logic [DW-1:0] rsp_rdata;
`ifdef DMEM_MISALIGN_ERR_EN
  logic          rsp_err;
`endif

  dmem_responder #(.ADDRESS_WIDTH(AW), .DATA_WIDTH(DW), .LATENCY(LAT)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_we    (req_we),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .req_be    (req_be),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_rdata (rsp_rdata)
`ifdef DMEM_MISALIGN_ERR_EN
    ,
    .rsp_err   (rsp_err)
`endif
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [DW-1:0] rdata;
    logic          err;
  } exp_t;

  exp_t          sb[$];
  logic [DW-1:0] model [64];
  int            checks = 0;
  int            errors = 0;

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic bit be_ok(input logic [NB-1:0] be);
    case (be)
      4'b0000, 4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0011, 4'b1100, 4'b1111: be_ok = 1'b1;
      default: be_ok = 1'b0;
    endcase
  endfunction

  function automatic bit misaligned(input logic we, input logic [AW-1:0] addr, input logic [NB-1:0] be);
`ifdef DMEM_MISALIGN_ERR_EN
    misaligned = we ? !be_ok(be) : (addr[1:0] != 2'b00);
`else
    misaligned = 1'b0;
`endif
  endfunction

  // Present a request, wait for acceptance, then record its expected response.
  task automatic issue(input string tag, input logic we, input logic [AW-1:0] addr,
                       input logic [DW-1:0] wdata, input logic [NB-1:0] be,
                       input bit hold, input bit aborted);
    int   n;
    int   idx;
    exp_t e;
    req_valid = 1'b1;
    req_we    = we;
    req_addr  = addr;
    req_wdata = wdata;
    req_be    = be;
    n = 0;
    while (!req_ready && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    if (!req_ready) begin
      chk({tag, "_accept"}, 32'(req_ready), 32'd1);
      req_valid = 1'b0;
      return;
    end
    @(posedge clk); #1;
    if (!hold) req_valid = 1'b0;
    if (aborted) return;
    idx = int'(addr[AW-1:2]);
    if (misaligned(we, addr, be)) begin
      e.rdata = '0;
      e.err   = 1'b1;
    end else if (we) begin
      for (int i = 0; i < NB; i++) begin
        if (be[i]) model[idx][i*8 +: 8] = wdata[i*8 +: 8];
      end
      e.rdata = '0;
      e.err   = 1'b0;
    end else begin
      e.rdata = model[idx];
      e.err   = 1'b0;
    end
    sb.push_back(e);
  endtask

  task automatic wait_rsp(input string tag);
    int   n;
    exp_t e;
    n = 0;
    while (!rsp_valid && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
    chk({tag, "_latency"}, 32'(n), 32'(LAT));
    if (sb.size() == 0) begin
      chk({tag, "_sb_empty"}, 32'(sb.size()), 32'd1);
      return;
    end
    e = sb.pop_front();
    chk({tag, "_rdata"}, rsp_rdata, e.rdata);
`ifdef DMEM_MISALIGN_ERR_EN
    chk({tag, "_err"}, 32'(rsp_err), 32'(e.err));
`endif
  endtask

  task automatic handshake(input string tag);
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    chk({tag, "_valid_drop"}, 32'(rsp_valid), 32'd0);
  endtask

  task automatic txn(input string tag, input logic we, input logic [AW-1:0] addr,
                     input logic [DW-1:0] wdata, input logic [NB-1:0] be);
    issue(tag, we, addr, wdata, be, 1'b0, 1'b0);
    wait_rsp(tag);
    handshake(tag);
  endtask

  initial begin
    // Reset state
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_rsp_rdata", rsp_rdata, 32'd0);
    rst = 1'b1;
    @(posedge clk); #1;
    chk("rst_req_ready", 32'(req_ready), 32'd1);

    // Basic store/load, address offset ignored, partial and empty byte enables
    txn("st_full",   1'b1, 8'h10, 32'hDEADBEEF, 4'b1111);
    txn("ld_10",     1'b0, 8'h10, 32'h0,        4'b0000);
    txn("ld_13",     1'b0, 8'h13, 32'h0,        4'b1111);
    txn("st_lane0",  1'b1, 8'h10, 32'h000000AA, 4'b0001);
    txn("ld_lane0",  1'b0, 8'h10, 32'h0,        4'b0000);
    txn("st_be0",    1'b1, 8'h10, 32'hFFFFFFFF, 4'b0000);
    txn("ld_be0",    1'b0, 8'h10, 32'h0,        4'b0000);
    txn("ld_wrap",   1'b0, 8'hD0, 32'h0,        4'b0000);

    // Backpressure with a second request held pending
    txn("st_20",     1'b1, 8'h20, 32'hDEADBEEF, 4'b1111);
    issue("bp_ld", 1'b0, 8'h20, 32'h0, 4'b0000, 1'b1, 1'b0);
    req_we    = 1'b1;
    req_addr  = 8'h30;
    req_wdata = 32'h00000055;
    req_be    = 4'b1111;
    wait_rsp("bp_ld");
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      chk("bp_valid_hold", 32'(rsp_valid), 32'd1);
      chk("bp_rdata_hold", rsp_rdata, 32'hDEADBEEF);
      chk("bp_ready_low", 32'(req_ready), 32'd0);
    end
    handshake("bp_ld");
    chk("bp_ready_after_hs", 32'(req_ready), 32'd1);
    issue("bp_st", 1'b1, 8'h30, 32'h00000055, 4'b1111, 1'b0, 1'b0);
    chk("bp_st_busy", 32'(req_ready), 32'd0);
    wait_rsp("bp_st");
    handshake("bp_st");
    txn("ld_30",     1'b0, 8'h30, 32'h0,        4'b0000);

    // Reset during BUSY aborts the store
    issue("abort_st", 1'b1, 8'h20, 32'h12345678, 4'b1111, 1'b0, 1'b1);
    rst = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      chk("abort_no_rsp", 32'(rsp_valid), 32'd0);
    end
    txn("ld_after_abort", 1'b0, 8'h20, 32'h0, 4'b0000);

    // rsp_ready held high outside RESP changes nothing
    rsp_ready = 1'b1;
    txn("ld_rdy_early", 1'b0, 8'h30, 32'h0, 4'b0000);

    // Byte-enable patterns that are illegal only when misalignment checking is built in
    txn("st_be0101", 1'b1, 8'h30, 32'hFFFFFFFF, 4'b0101);
    txn("ld_be0101", 1'b0, 8'h30, 32'h0,        4'b0000);
    txn("st_be1100", 1'b1, 8'h30, 32'hAABB0000, 4'b1100);
    txn("ld_be1100", 1'b0, 8'h30, 32'h0,        4'b0000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/dmem_responder.md
DMEM_RESPONDER -- requirements
Module: dmem_responder

Interface
REQ-001 The block SHALL have parameter ADDRESS_WIDTH, default 8: byte-address width, giving 2^(ADDRESS_WIDTH-2) words.
REQ-002 The block SHALL have parameter DATA_WIDTH, default 32: word width, split into DATA_WIDTH/8 byte lanes.
REQ-003 The block SHALL have parameter LATENCY, default 2: cycles from request acceptance to response; legal range 1..15.
REQ-004 The block SHALL have port clk, input, 1 bit: single clock, all logic on the rising edge.
REQ-005 The block SHALL have port rst, input, 1 bit: reset, synchronous, active-low (0 = reset).
REQ-006 The block SHALL have port req_valid, input, 1 bit: the initiator presents a request.
REQ-007 The block SHALL have port req_ready, output, 1 bit: the responder can accept a request.
REQ-008 The block SHALL have port req_we, input, 1 bit: 1 = store, 0 = load.
REQ-009 The block SHALL have port req_addr, input, ADDRESS_WIDTH bits: byte address.
REQ-010 The block SHALL have port req_wdata, input, DATA_WIDTH bits: store data.
REQ-011 The block SHALL have port req_be, input, DATA_WIDTH/8 bits: store byte enables.
REQ-012 The block SHALL have port rsp_valid, output, 1 bit: a response is presented.
REQ-013 The block SHALL have port rsp_ready, input, 1 bit: the initiator accepts the response.
REQ-014 The block SHALL have port rsp_rdata, output, DATA_WIDTH bits: load data.

Function
REQ-015 The block SHALL implement an FSM with states IDLE, BUSY and RESP, plus a down-counter cnt of 4 bits.
REQ-016 req_ready SHALL be 1 only in IDLE; a request is accepted on an edge where req_valid and req_ready are both 1.
REQ-017 On acceptance the block SHALL capture req_we, req_addr, req_wdata and req_be, load cnt = LATENCY-1, and enter BUSY; request inputs are ignored at all other times.
REQ-018 In BUSY, the block SHALL decrement cnt when cnt != 0, and when cnt == 0 SHALL perform the access and enter RESP, so that rsp_valid first rises after edge k+LATENCY, where k is the acceptance edge.
REQ-019 The word index SHALL be addr[ADDRESS_WIDTH-1:2]; addr[1:0] is ignored, so there is no out-of-range access and indices wrap naturally.
REQ-020 A store SHALL write only the lanes whose req_be bit is 1; be = 0 changes nothing but still produces a response; rsp_rdata for a store SHALL be 0.
REQ-021 A load SHALL register the full addressed word into rsp_rdata at the BUSY-to-RESP edge; req_be is ignored for loads.
REQ-022 In RESP, rsp_valid and rsp_rdata SHALL stay stable until an edge with rsp_ready = 1; that edge returns the FSM to IDLE.
REQ-023 rsp_valid SHALL be 1 only in RESP; a new request can be accepted no earlier than the cycle after the response handshake (minimum LATENCY+2 cycles per transaction).
REQ-024 A load issued after a completed store to the same word SHALL return the stored data.
REQ-025 rsp_ready asserted outside RESP SHALL have no effect.

Reset
REQ-026 While rst = 0 at an edge, the block SHALL go to IDLE with cnt = 0, rsp_valid = 0 and rsp_rdata = 0; req_ready reads 1 after the first edge with rst = 1.
REQ-027 Reset during BUSY SHALL abort the transaction: the store is not committed and no response is issued.
REQ-028 Reset SHALL NOT clear memory contents; there is no power-up value guarantee.

Configuration
REQ-029 With macro DMEM_MISALIGN_ERR_EN defined, the block SHALL add output rsp_err (1 bit, reset 0, valid with rsp_valid).
REQ-030 With DMEM_MISALIGN_ERR_EN defined, rsp_err SHALL be 1 for a store whose be is not 0000, 0001, 0010, 0100, 1000, 0011, 1100 or 1111, or for a load with addr[1:0] != 00; such an access writes nothing and returns rdata 0.
REQ-031 Without DMEM_MISALIGN_ERR_EN, rsp_err SHALL be absent and every be/addr pattern SHALL be handled per REQ-019..021.

Verification
REQ-032 Reset then store 0xDEADBEEF to addr 0x10 with be=1111 and LATENCY=2 -> rsp_valid rises after the second edge following acceptance, with rsp_rdata = 0.
REQ-033 Load from 0x10 -> rsp_rdata = 0xDEADBEEF; load from 0x13 -> rsp_rdata = 0xDEADBEEF (offset ignored).
REQ-034 Store 0x000000AA to 0x10 with be=0001 then load 0x10 -> rsp_rdata = 0xDEADBEAA; store with be=0000 -> the word is unchanged.
REQ-035 Hold rsp_ready = 0 for 5 cycles -> rsp_valid and rsp_rdata stay stable and req_ready stays 0; keeping req_valid high throughout -> the second request is accepted only in the cycle after the handshake.
REQ-036 Assert rst = 0 one cycle after accepting a store of 0x12345678 to 0x20, which held 0xDEADBEEF -> no response; a later load of 0x20 returns 0xDEADBEEF.
REQ-037 With DMEM_MISALIGN_ERR_EN, store with be=0101 -> rsp_err = 1 and memory unchanged; store with be=1100 -> rsp_err = 0.
